avl_mem_responder: RTL

Avalon-MM burst slave that plays the memory-controller end of the DDR2 Avalon interface driven by the L2 cache. It stores full cache-line words in on-chip RAM, accepts byte-enabled write bursts, and returns read bursts after a fixed, parameterised latency with back-pressure via `avl_ready`. It stands in for the DDR2 controller in simulation and in FPGA builds without external memory, and lets the L2 refill and writeback paths be exercised deterministically.

---
 rtl/avl_mem_responder_pkg.sv | 28 ++
 rtl/avl_mem_responder_if.sv | 31 +++
 rtl/avl_mem_responder_ram.sv | 42 ++++
 rtl/avl_mem_responder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/avl_mem_responder_pkg.sv
// Shared types, constants and the address-wrap helper for the Avalon memory responder.
package avl_resp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrBurst,
        StRdWait,
        StRdBurst
    } state_e;

    // Latency counter width; covers READ_LATENCY up to 15.
    localparam int unsigned LatCntW = 4;

    // RAM index width; the top-level MEM_DEPTH_BITS defaults to this and must match it.
    localparam int unsigned MemDepthBits = 10;

    // Width of the beat offset fed to wrap_idx; wide enough for any burstcount.
    localparam int unsigned MaxOffsetW = 8;

    // RAM index of beat 'offset' in a burst starting at 'base', wrapping at the RAM depth.
    function automatic logic [MemDepthBits-1:0] wrap_idx(input logic [MemDepthBits-1:0] base,
                                                         input logic [MaxOffsetW-1:0]   offset);
        logic [MemDepthBits-1:0] off_t;
        off_t = MemDepthBits'(offset);
        return base + off_t;
    endfunction

endpackage

// File: rtl/avl_mem_responder_if.sv
// Avalon-MM burst bus between the L2 cache (master) and the memory responder (slave).
interface avl_mem_responder_if #(
    parameter int unsigned AVL_ADDR       = 30,
    parameter int unsigned AVL_SIZE       = 3,
    parameter int unsigned AVL_BE         = 32,
    parameter int unsigned AVL_DATA_WIDTH = 256
);
    logic [AVL_ADDR-1:0]       avl_addr;
    logic [AVL_SIZE-1:0]       avl_size;
    logic [AVL_DATA_WIDTH-1:0] avl_wdata;
    logic [AVL_BE-1:0]         avl_be;
    logic                      avl_write_req;
    logic                      avl_read_req;
    logic                      avl_burstbegin;
    logic                      avl_ready;
    logic [AVL_DATA_WIDTH-1:0] avl_rdata;
    logic                      avl_rdata_valid;
    logic                      proto_err;

    modport slave (
        input  avl_addr, avl_size, avl_wdata, avl_be, avl_write_req, avl_read_req,
               avl_burstbegin,
        output avl_ready, avl_rdata, avl_rdata_valid, proto_err
    );

    modport master (
        output avl_addr, avl_size, avl_wdata, avl_be, avl_write_req, avl_read_req,
               avl_burstbegin,
        input  avl_ready, avl_rdata, avl_rdata_valid, proto_err
    );
endinterface

// File: rtl/avl_mem_responder_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module avl_resp_ram #(
    parameter int unsigned DataWidth = 256,
    parameter int unsigned BeWidth   = 32,
    parameter int unsigned DepthBits = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [DepthBits-1:0] addr_i,
    input  logic [BeWidth-1:0]   be_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic [DataWidth-1:0] rdata_o
);
    localparam int unsigned Depth = 2 ** DepthBits;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rdata_q;

    // Byte-masked write; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < BeWidth; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Registered read data, cleared by reset so the bus output starts at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/avl_mem_responder.sv
// Avalon-MM burst slave standing in for the DDR2 controller: byte-enabled write bursts into
// on-chip RAM, read bursts returned after a fixed latency, sticky protocol-error flag.
module avl_mem_responder
    import avl_resp_pkg::*;
#(
    parameter int unsigned AVL_ADDR       = 30,
    parameter int unsigned AVL_SIZE       = 3,
    parameter int unsigned AVL_BE         = 32,
    parameter int unsigned AVL_DATA_WIDTH = 256,
    parameter int unsigned MEM_DEPTH_BITS = MemDepthBits,
    parameter int unsigned READ_LATENCY   = 4
) (
    input logic                clk,
    input logic                reset,
    avl_mem_responder_if.slave avl
);
    // RD_WAIT spans READ_LATENCY-1 edges; the extra edge is the RAM read register.
    localparam logic [LatCntW-1:0] LatLoad = LatCntW'(READ_LATENCY - 2);

    state_e                    state_q, state_d;
    logic [MEM_DEPTH_BITS-1:0] base_q, base_d;
    logic [AVL_SIZE-1:0]       beat_q, beat_d;
    logic [AVL_SIZE-1:0]       off_q, off_d;
    logic [LatCntW-1:0]        lat_q, lat_d;
    logic                      ready_q, ready_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;

    logic                      ram_we, ram_re;
    logic [MEM_DEPTH_BITS-1:0] ram_addr;
    logic [MEM_DEPTH_BITS-1:0] req_idx;
    logic [AVL_SIZE-1:0]       size_m1;
    logic                      size_zero;
    logic                      unused_addr_hi;

    assign req_idx        = avl.avl_addr[MEM_DEPTH_BITS-1:0];
    assign size_zero      = (avl.avl_size == '0);
    // A burstcount of zero is handled as a single beat.
    assign size_m1        = size_zero ? '0 : avl.avl_size - AVL_SIZE'(1);
    assign unused_addr_hi = ^avl.avl_addr[AVL_ADDR-1:MEM_DEPTH_BITS];

    // Next-state, counters, RAM controls and registered-output next values.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        beat_d   = beat_q;
        off_d    = off_q;
        lat_d    = lat_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = wrap_idx(base_q, MaxOffsetW'(off_q));

        unique case (state_q)
            StIdle: begin
                if (ready_q && avl.avl_write_req) begin
                    // Write wins over a simultaneous read, which is dropped.
                    ram_we   = 1'b1;
                    ram_addr = req_idx;
                    base_d   = req_idx;
                    beat_d   = size_m1;
                    off_d    = AVL_SIZE'(1);
                    if (size_zero || avl.avl_read_req) err_d = 1'b1;
                    if (size_m1 != '0) state_d = StWrBurst;
                end else if (ready_q && avl.avl_read_req) begin
                    base_d  = req_idx;
                    beat_d  = size_m1;
                    off_d   = '0;
                    lat_d   = LatLoad;
                    if (size_zero) err_d = 1'b1;
                    state_d = StRdWait;
                end
            end
            StWrBurst: begin
                if (avl.avl_read_req || avl.avl_burstbegin) err_d = 1'b1;
                // beat_q holds the beats still owed; a deasserted write_req is a wait beat.
                if (avl.avl_write_req) begin
                    ram_we = 1'b1;
                    off_d  = off_q + AVL_SIZE'(1);
                    beat_d = beat_q - AVL_SIZE'(1);
                    if (beat_q == AVL_SIZE'(1)) state_d = StIdle;
                end
            end
            StRdWait: begin
                if (lat_q == '0) begin
                    state_d = StRdBurst;
                end else begin
                    lat_d = lat_q - LatCntW'(1);
                end
            end
            StRdBurst: begin
                // beat_q holds the beats remaining after the one issued this cycle.
                ram_re  = 1'b1;
                valid_d = 1'b1;
                off_d   = off_q + AVL_SIZE'(1);
                if (beat_q == '0) begin
                    state_d = StIdle;
                end else begin
                    beat_d = beat_q - AVL_SIZE'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Ready stays low for one cycle after the last read beat so commands never overlap data.
        ready_d = ((state_d == StIdle) || (state_d == StWrBurst)) && (state_q != StRdBurst);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            base_q  <= '0;
            beat_q  <= '0;
            off_q   <= '0;
            lat_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            off_q   <= off_d;
            lat_q   <= lat_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    avl_resp_ram #(
        .DataWidth (AVL_DATA_WIDTH),
        .BeWidth   (AVL_BE),
        .DepthBits (MEM_DEPTH_BITS)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .be_i    (avl.avl_be),
        .wdata_i (avl.avl_wdata),
        .rdata_o (avl.avl_rdata)
    );

    assign avl.avl_ready       = ready_q;
    assign avl.avl_rdata_valid = valid_q;
    assign avl.proto_err       = err_q;
endmodule
